// File: rtl/mips_trace_buffer_if.sv
// Probe and trace-drain bundle for mips_trace_buffer. The slave modport is the
// buffer itself; the master modport is the CPU probe driver plus the drain consumer.
interface mips_trace_buffer_if #(
  parameter int CYCLE_W = 16,
  parameter int LEVEL_W = 5,
  parameter int DROP_W  = 8
);
  logic               capture_en;
  logic [31:0]        pc_out;
  logic [31:0]        instruction;
  logic               RegWrite;
  logic [4:0]         write_register;
  logic [31:0]        write_data;
  logic               MemWrite;
  logic [31:0]        ALU_res;
  logic [31:0]        read_data2;
  logic               trace_ready;
  logic               trace_valid;
  logic [1:0]         trace_kind;
  logic [CYCLE_W-1:0] trace_cycle;
  logic [31:0]        trace_pc;
  logic [31:0]        trace_instr;
  logic [31:0]        trace_addr;
  logic [31:0]        trace_data;
  logic [LEVEL_W-1:0] level;
  logic [DROP_W-1:0]  drop_count;

  modport slave (
    input  capture_en, pc_out, instruction, RegWrite, write_register, write_data,
           MemWrite, ALU_res, read_data2, trace_ready,
    output trace_valid, trace_kind, trace_cycle, trace_pc, trace_instr,
           trace_addr, trace_data, level, drop_count
  );

  modport master (
    output capture_en, pc_out, instruction, RegWrite, write_register, write_data,
           MemWrite, ALU_res, read_data2, trace_ready,
    input  trace_valid, trace_kind, trace_cycle, trace_pc, trace_instr,
           trace_addr, trace_data, level, drop_count
  );
endinterface

// File: rtl/mips_trace_buffer.sv
// Commit-trace capture FIFO: time-stamps qualifying register writes and stores
// from the MIPS core and presents them show-ahead on a valid/ready drain port.
module mips_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int CYCLE_W = 16,
  parameter int DROP_W  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_trace_buffer_if.slave    bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]         kind;
    logic [CYCLE_W-1:0] cycle;
    logic [31:0]        pc;
    logic [31:0]        instr;
    logic [31:0]        addr;
    logic [31:0]        data;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W:0]     r_wrPtr;
  logic [PTR_W:0]     r_rdPtr;
  logic [CYCLE_W-1:0] r_cycle;
  logic [DROP_W-1:0]  r_drop;

  logic               w_regQual;
  logic               w_memQual;
  logic               w_event;
  logic [LEVEL_W-1:0] w_level;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  entry_t             w_new;
  entry_t             w_head;

  // A write to $zero never counts; both strobes together encode ERR as kind 11.
  assign w_regQual = bus.capture_en && bus.RegWrite && (bus.write_register != 5'd0);
  assign w_memQual = bus.capture_en && bus.MemWrite;
  assign w_event   = w_regQual || w_memQual;

  assign w_level = r_wrPtr - r_rdPtr;
  assign w_empty = (w_level == '0);
  assign w_full  = (w_level == LEVEL_W'(DEPTH));
  assign w_pop   = !w_empty && bus.trace_ready;
  assign w_push  = w_event && (!w_full || w_pop);

  always_comb begin
    w_new       = '0;
    w_new.kind  = {w_memQual, w_regQual};
    w_new.cycle = r_cycle;
    w_new.pc    = bus.pc_out;
    w_new.instr = bus.instruction;
    if (w_regQual && !w_memQual) begin
      w_new.addr = {27'd0, bus.write_register};
      w_new.data = bus.write_data;
    end else if (w_memQual && !w_regQual) begin
      w_new.addr = bus.ALU_res;
      w_new.data = bus.read_data2;
    end else begin
      w_new.addr = bus.ALU_res;
      w_new.data = bus.write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[PTR_W-1:0]] <= w_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_cycle <= '0;
      r_drop  <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_event && !w_push && (r_drop != '1)) begin
        r_drop <= r_drop + 1'b1;
      end
    end
  end

  // Empty pointers after reset force every trace field to zero without a clock.
  always_comb begin
    w_head          = r_mem[r_rdPtr[PTR_W-1:0]];
    bus.trace_valid = 1'b0;
    bus.trace_kind  = '0;
    bus.trace_cycle = '0;
    bus.trace_pc    = '0;
    bus.trace_instr = '0;
    bus.trace_addr  = '0;
    bus.trace_data  = '0;
    if (!w_empty) begin
      bus.trace_valid = 1'b1;
      bus.trace_kind  = w_head.kind;
      bus.trace_cycle = w_head.cycle;
      bus.trace_pc    = w_head.pc;
      bus.trace_instr = w_head.instr;
      bus.trace_addr  = w_head.addr;
      bus.trace_data  = w_head.data;
    end
  end

  assign bus.level      = w_level;
  assign bus.drop_count = r_drop;
endmodule

// File: tb/tb_mips_trace_buffer.sv
// Directed bench for mips_trace_buffer: a vector table for the basic capture and
// drain behaviour, then hand sequences for overflow, wrap, saturation and reset.
module tb_mips_trace_buffer;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] tbCycle;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  mips_trace_buffer_if #(.CYCLE_W(16), .LEVEL_W(5), .DROP_W(8)) bus ();
  mips_trace_buffer_if #(.CYCLE_W(4), .LEVEL_W(3), .DROP_W(8)) bus2 ();

  mips_trace_buffer #(.DEPTH(16), .CYCLE_W(16), .DROP_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  mips_trace_buffer #(.DEPTH(4), .CYCLE_W(4), .DROP_W(8)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  // Reference timestamp: number of edges seen since reset was last released.
  always @(posedge clk or posedge reset) begin
    if (reset) tbCycle <= 32'd0;
    else       tbCycle <= tbCycle + 32'd1;
  end

  typedef struct {
    logic        capEn;
    logic        regWr;
    logic [4:0]  wReg;
    logic [31:0] wData;
    logic        memWr;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ready;
    logic        expValid;
    logic [1:0]  expKind;
    logic [15:0] expCycle;
    logic [31:0] expPc;
    logic [31:0] expInstr;
    logic [31:0] expAddr;
    logic [31:0] expData;
    logic [4:0]  expLevel;
    logic [7:0]  expDrop;
  } vec_t;

  vec_t vecs [12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleProbes();
    bus.capture_en = 1'b1;  bus.RegWrite = 1'b0;  bus.write_register = 5'd0;
    bus.write_data = 32'd0; bus.MemWrite = 1'b0;  bus.ALU_res = 32'd0;
    bus.read_data2 = 32'd0; bus.pc_out = 32'd0;   bus.instruction = 32'd0;
    bus.trace_ready = 1'b0;
    bus2.capture_en = 1'b1;  bus2.RegWrite = 1'b0;  bus2.write_register = 5'd0;
    bus2.write_data = 32'd0; bus2.MemWrite = 1'b0;  bus2.ALU_res = 32'd0;
    bus2.read_data2 = 32'd0; bus2.pc_out = 32'd0;   bus2.instruction = 32'd0;
    bus2.trace_ready = 1'b0;
  endtask

  task automatic randomProbes();
    bus.capture_en = 1'($urandom);      bus.RegWrite = 1'($urandom);
    bus.write_register = 5'($urandom);  bus.write_data = $urandom;
    bus.MemWrite = 1'($urandom);        bus.ALU_res = $urandom;
    bus.read_data2 = $urandom;          bus.pc_out = $urandom;
    bus.instruction = $urandom;         bus.trace_ready = 1'($urandom);
    bus2.capture_en = 1'b1;             bus2.MemWrite = 1'($urandom);
    bus2.ALU_res = $urandom;
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.capture_en = v.capEn;  bus.RegWrite = v.regWr;  bus.write_register = v.wReg;
    bus.write_data = v.wData;  bus.MemWrite = v.memWr;  bus.ALU_res = v.alu;
    bus.read_data2 = v.rd2;    bus.pc_out = v.pc;       bus.instruction = v.instr;
    bus.trace_ready = v.ready;
  endtask

  task automatic checkHead(input string tag, input logic expValid, input logic [1:0] expKind,
                           input logic [15:0] expCycle, input logic [31:0] expPc,
                           input logic [31:0] expInstr, input logic [31:0] expAddr,
                           input logic [31:0] expData, input logic [4:0] expLevel,
                           input logic [7:0] expDrop);
    checkOutput({tag, " valid"}, 32'(bus.trace_valid), 32'(expValid));
    checkOutput({tag, " kind"},  32'(bus.trace_kind),  32'(expKind));
    checkOutput({tag, " cycle"}, 32'(bus.trace_cycle), 32'(expCycle));
    checkOutput({tag, " pc"},    bus.trace_pc,          expPc);
    checkOutput({tag, " instr"}, bus.trace_instr,       expInstr);
    checkOutput({tag, " addr"},  bus.trace_addr,        expAddr);
    checkOutput({tag, " data"},  bus.trace_data,        expData);
    checkOutput({tag, " level"}, 32'(bus.level),        32'(expLevel));
    checkOutput({tag, " drop"},  32'(bus.drop_count),   32'(expDrop));
  endtask

  initial begin
    logic [31:0] firstStamp;
    logic [31:0] pushStamp;
    logic [31:0] expAddr;
    logic [31:0] expStamp;

    // Each row is sampled at edge i (timestamp i) and checked just after it.
    vecs[0]  = '{1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 32'h0,   32'h0,    32'h0,        32'h0,        1'b0,
                 1'b0, 2'b00, 16'd0,  32'h0,        32'h0,        32'h0,  32'h0,    5'd0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 5'd4,  32'h1111, 1'b0, 32'h44,  32'h2222, 32'h00400000, 32'h0,        1'b1,
                 1'b0, 2'b00, 16'd0,  32'h0,        32'h0,        32'h0,  32'h0,    5'd0, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b0, 32'h0,   32'h0,    32'h0,        32'h0,        1'b0,
                 1'b0, 2'b00, 16'd0,  32'h0,        32'h0,        32'h0,  32'h0,    5'd0, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 5'd8,  32'h5,    1'b0, 32'h0,   32'h0,    32'h00400004, 32'h01095020, 1'b0,
                 1'b1, 2'b01, 16'd3,  32'h00400004, 32'h01095020, 32'h8,  32'h5,    5'd1, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b0, 32'h0,   32'h0,    32'h00400008, 32'h0,        1'b1,
                 1'b0, 2'b00, 16'd0,  32'h0,        32'h0,        32'h0,  32'h0,    5'd0, 8'd0};
    vecs[5]  = '{1'b1, 1'b1, 5'd0,  32'hDEAD, 1'b0, 32'h0,   32'h0,    32'h0040000C, 32'h00004020, 1'b0,
                 1'b0, 2'b00, 16'd0,  32'h0,        32'h0,        32'h0,  32'h0,    5'd0, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 5'd7,  32'h77,   1'b1, 32'h40,  32'h88,   32'h00400010, 32'h0,        1'b0,
                 1'b0, 2'b00, 16'd0,  32'h0,        32'h0,        32'h0,  32'h0,    5'd0, 8'd0};
    vecs[7]  = '{1'b1, 1'b1, 5'd9,  32'h99,   1'b1, 32'h10,  32'h55,   32'h00400014, 32'hAD290000, 1'b0,
                 1'b1, 2'b11, 16'd7,  32'h00400014, 32'hAD290000, 32'h10, 32'h99,   5'd1, 8'd0};
    vecs[8]  = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b1, 32'h20,  32'hABCD, 32'h00400018, 32'hAC0A0000, 1'b0,
                 1'b1, 2'b11, 16'd7,  32'h00400014, 32'hAD290000, 32'h10, 32'h99,   5'd2, 8'd0};
    vecs[9]  = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b0, 32'h0,   32'h0,    32'h0040001C, 32'h0,        1'b1,
                 1'b1, 2'b10, 16'd8,  32'h00400018, 32'hAC0A0000, 32'h20, 32'hABCD, 5'd1, 8'd0};
    vecs[10] = '{1'b1, 1'b1, 5'd31, 32'h1234, 1'b0, 32'h999, 32'h888,  32'h00400020, 32'h03E0F820, 1'b1,
                 1'b1, 2'b01, 16'd10, 32'h00400020, 32'h03E0F820, 32'd31, 32'h1234, 5'd1, 8'd0};
    vecs[11] = '{1'b1, 1'b0, 5'd0,  32'h0,    1'b0, 32'h0,   32'h0,    32'h00400024, 32'h0,        1'b1,
                 1'b0, 2'b00, 16'd0,  32'h0,        32'h0,        32'h0,  32'h0,    5'd0, 8'd0};

    reset = 1'b1;
    idleProbes();
    for (int i = 0; i < 3; i++) begin
      randomProbes();
      tick();
      checkHead($sformatf("reset%0d", i), 1'b0, 2'b00, 16'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 8'd0);
    end
    idleProbes();
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkHead($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expKind, vecs[i].expCycle,
                vecs[i].expPc, vecs[i].expInstr, vecs[i].expAddr, vecs[i].expData,
                vecs[i].expLevel, vecs[i].expDrop);
    end
    idleProbes();

    // Overflow: 20 stores into a 16-deep FIFO with nobody draining.
    firstStamp = tbCycle;
    for (int i = 0; i < 20; i++) begin
      bus.MemWrite = 1'b1;
      bus.ALU_res = 32'(i);
      bus.read_data2 = 32'hA000 + 32'(i);
      bus.pc_out = 32'h00400100 + 32'(4 * i);
      tick();
    end
    idleProbes();
    checkOutput("ovf level", 32'(bus.level), 32'd16);
    checkOutput("ovf drop", 32'(bus.drop_count), 32'd4);
    checkOutput("ovf head addr", bus.trace_addr, 32'd0);
    checkOutput("ovf head kind", 32'(bus.trace_kind), 32'd2);
    checkOutput("ovf head data", bus.trace_data, 32'hA000);
    checkOutput("ovf head cycle", 32'(bus.trace_cycle), 32'(firstStamp[15:0]));

    // Full FIFO with a store and a pop in the same cycle.
    pushStamp = tbCycle;
    bus.MemWrite = 1'b1;
    bus.ALU_res = 32'h100;
    bus.read_data2 = 32'hB000;
    bus.trace_ready = 1'b1;
    tick();
    idleProbes();
    checkOutput("fullpp level", 32'(bus.level), 32'd16);
    checkOutput("fullpp drop", 32'(bus.drop_count), 32'd4);
    checkOutput("fullpp head addr", bus.trace_addr, 32'd1);

    for (int i = 0; i < 16; i++) begin
      expAddr  = (i < 15) ? 32'(i + 1) : 32'h100;
      expStamp = (i < 15) ? firstStamp + 32'(i + 1) : pushStamp;
      checkOutput($sformatf("drain%0d valid", i), 32'(bus.trace_valid), 32'd1);
      checkOutput($sformatf("drain%0d addr", i), bus.trace_addr, expAddr);
      checkOutput($sformatf("drain%0d cycle", i), 32'(bus.trace_cycle), 32'(expStamp[15:0]));
      bus.trace_ready = 1'b1;
      tick();
      bus.trace_ready = 1'b0;
    end
    checkOutput("drained valid", 32'(bus.trace_valid), 32'd0);
    checkOutput("drained level", 32'(bus.level), 32'd0);
    checkOutput("drained addr", bus.trace_addr, 32'd0);

    // Timestamp wrap on the 4-bit-counter instance: events at counter 15 and 16.
    for (int k = 0; k < 40 && tbCycle[3:0] != 4'hF; k++) tick();
    checkOutput("wrap align", 32'(tbCycle[3:0]), 32'd15);
    bus2.MemWrite = 1'b1;
    bus2.ALU_res = 32'h55;
    tick();
    bus2.ALU_res = 32'h66;
    tick();
    bus2.MemWrite = 1'b0;
    checkOutput("wrap level", 32'(bus2.level), 32'd2);
    checkOutput("wrap first addr", bus2.trace_addr, 32'h55);
    checkOutput("wrap first cycle", 32'(bus2.trace_cycle), 32'd15);
    bus2.trace_ready = 1'b1;
    tick();
    bus2.trace_ready = 1'b0;
    checkOutput("wrap second addr", bus2.trace_addr, 32'h66);
    checkOutput("wrap second cycle", 32'(bus2.trace_cycle), 32'd0);
    bus2.trace_ready = 1'b1;
    tick();
    bus2.trace_ready = 1'b0;
    checkOutput("wrap empty", 32'(bus2.trace_valid), 32'd0);

    // Drop counter saturation: fill, then keep storing well past 255 losses.
    for (int i = 0; i < 280; i++) begin
      bus.MemWrite = 1'b1;
      bus.ALU_res = 32'(i);
      tick();
    end
    idleProbes();
    checkOutput("sat drop", 32'(bus.drop_count), 32'd255);
    checkOutput("sat level", 32'(bus.level), 32'd16);

    // A reset pulse between edges clears state without any clock edge.
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    checkOutput("pulse drop", 32'(bus.drop_count), 32'd0);
    checkOutput("pulse level", 32'(bus.level), 32'd0);
    tick();

    for (int i = 0; i < 5; i++) begin
      bus.MemWrite = 1'b1;
      bus.ALU_res = 32'h200 + 32'(i);
      tick();
    end
    idleProbes();
    checkOutput("queued level", 32'(bus.level), 32'd5);
    checkOutput("queued valid", 32'(bus.trace_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkHead("midreset", 1'b0, 2'b00, 16'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 8'd0);
    tick();
    reset = 1'b0;
    bus.RegWrite = 1'b1;
    bus.write_register = 5'd3;
    bus.write_data = 32'h77;
    bus.pc_out = 32'h00400200;
    tick();
    idleProbes();
    checkHead("postreset", 1'b1, 2'b01, 16'd0, 32'h00400200, 32'h0, 32'h3, 32'h77, 5'd1, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_trace_buffer.md
# mips_trace_buffer

Commit-trace capture buffer that sits directly downstream of the MIPS CPU. It samples the CPU's architectural write probes every clock: register-file writes (RegWrite, write_register, write_data) and data-memory stores (MemWrite, ALU_res, read_data2). Each qualifying commit becomes a time-stamped trace entry in a small FIFO. The bench or a debug port drains the FIFO through a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 16, number of FIFO entries; power of two, ≥2
- CYCLE_W, 16, width of the cycle timestamp counter
- DROP_W, 8, width of the saturating drop counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- capture_en  in  1  sample enable; 0 = ignore probes this cycle
- pc_out  in  32  PC of the instruction committing this cycle
- instruction  in  32  instruction word committing this cycle
- RegWrite  in  1  register-file write strobe
- write_register  in  5  destination register number
- write_data  in  32  register write value
- MemWrite  in  1  data-memory store strobe
- ALU_res  in  32  store address
- read_data2  in  32  store data
- trace_ready  in  1  consumer accepts head entry
- trace_valid  out  1  head entry present
- trace_kind  out  2  01 = REG, 10 = MEM, 11 = ERR (both strobes)
- trace_cycle  out  CYCLE_W  timestamp of the entry
- trace_pc  out  32  captured pc_out
- trace_instr  out  32  captured instruction
- trace_addr  out  32  REG: zero-extended write_register; MEM or ERR: ALU_res
- trace_data  out  32  REG or ERR: write_data; MEM: read_data2
- level  out  $clog2(DEPTH)+1  current occupancy
- drop_count  out  DROP_W  events lost to overflow; saturating

## Operation
- Cycle counter: free-running and increments every clock regardless of capture_en. It wraps modulo 2^CYCLE_W. An entry's timestamp is the counter value before the increment at the sampling edge.
- Event qualification at each edge, only when capture_en=1:
  - REG: RegWrite=1, write_register≠0, MemWrite=0.
  - MEM: MemWrite=1 and REG not qualified.
  - ERR: RegWrite=1, write_register≠0, MemWrite=1.
  - Writes to $zero are never recorded.
  - At most one entry per cycle.
- FIFO:
  - Circular array of DEPTH entries.
  - Read and write pointers carry one extra wrap bit.
  - full = (level==DEPTH); empty = (level==0).
- Pop: trace_valid && trace_ready; the head pointer advances.
- Push: event && (!full || pop). A push with full and no pop is dropped, and drop_count increments, saturating at 2^DROP_W−1.
- Outputs:
  - Show-ahead: the head entry drives the trace_* fields combinationally from the array.
  - All trace_* data fields are forced to 0 whenever trace_valid=0.
- Reset: asynchronous. Assertion immediately clears pointers, level, drop_count, cycle counter and trace_valid, and zeroes all outputs. Array contents need not be cleared.

## Timing
- Capture latency: an event sampled at edge N appears on the outputs after edge N. There is no fall-through: a push into an empty FIFO is visible one cycle later, never in the same cycle.
- Pop takes effect at the edge where valid&&ready=1. The next entry, or valid=0, is presented after that edge.
- Simultaneous push and pop:
  - Non-empty, non-full: level unchanged.
  - Full: both happen, no drop, level stays DEPTH.
  - Empty: pop is impossible (valid=0), so only the push happens.
- Pointer wrap: the index wraps at DEPTH; the extra bit toggles to distinguish full from empty.
- trace_ready is ignored when trace_valid=0.
- Reset mid-operation: outputs go to reset values without a clock edge. The first edge after deassertion samples with cycle timestamp 0.
- capture_en=0 with the strobes high: no entry and no drop, but the cycle counter still advances.

## Test plan
- Reset: assert reset for 3 cycles with random probes. Required: trace_valid=0, level=0, drop_count=0, all trace_* fields 0.
- Single REG commit:
  - Stimulus: capture_en=1, RegWrite=1, write_register=8, write_data=0x00000005, pc_out=0x00400004, at cycle 3.
  - Required next cycle: valid=1, kind=01, addr=8, data=5, pc=0x00400004, cycle=3.
  - Then trace_ready=1 for 1 cycle. Required: valid=0, level=0.
- Filtering and ERR:
  - RegWrite=1, write_register=0. Required: no entry.
  - RegWrite=1, write_register=9, MemWrite=1, ALU_res=0x10. Required: one entry, kind=11, addr=0x10.
- Overflow: DEPTH=16, trace_ready=0, 20 consecutive MEM stores with ALU_res=0..19. Required: level=16, drop_count=4. Draining yields addr 0..15 in order with consecutive cycle stamps.
- Full with simultaneous push and pop: FIFO full, one store and trace_ready=1 in the same cycle. Required: level stays 16, drop_count unchanged, new entry lands at the tail.
- Wrap and async reset:
  - CYCLE_W=4, events at counter 15 and 16. Required: stamps 15 then 0.
  - Assert reset between clock edges with 5 entries queued. Required: valid=0 and level=0 immediately.
